booth_pp_accumulator: RTL and testbench

BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

---
 rtl/booth_pkg.sv | 14 +
 rtl/booth_pp_accumulator_if.sv | 28 ++
 rtl/booth_pp_extend.sv | 18 +
 rtl/booth_pp_accumulator.sv | 118 +++++++++++
 tb/tb_booth_pp_accumulator.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared widths and FSM state encoding for the radix-4 Booth partial-product accumulator.
package booth_pkg;
    localparam int NUM_PP = 5;
    localparam int PP_W   = 9;
    localparam int ACC_W  = 18;
    localparam int PROD_W = 16;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/booth_pp_accumulator_if.sv
// Partial-product input handshake and product output handshake of the Booth accumulator.
interface booth_pp_accumulator_if;
    import booth_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_PP*PP_W-1:0]   pp_in;
    logic [NUM_PP-1:0]        booth_single;
    logic [NUM_PP-1:0]        booth_double;
    logic [NUM_PP-1:0]        booth_negtive;
    logic                     signed_mpy;
    logic                     mcand_msb;
    logic [PROD_W-1:0]        product;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_valid, pp_in, booth_single, booth_double, booth_negtive,
               signed_mpy, mcand_msb, out_ready,
        input  in_ready, product, out_valid
    );

    modport slave (
        input  in_valid, pp_in, booth_single, booth_double, booth_negtive,
               signed_mpy, mcand_msb, out_ready,
        output in_ready, product, out_valid
    );
endinterface

// File: rtl/booth_pp_extend.sv
// Sign-extends one Booth partial product to accumulator width and folds in the +1 of its negation.
module booth_pp_extend
    import booth_pkg::*;
(
    input  logic [PP_W-1:0]  pp,
    input  logic             single,
    input  logic             double,
    input  logic             neg,
    input  logic             signed_mpy,
    input  logic             mcand_msb,
    output logic [ACC_W-1:0] term
);
    logic ext;

    // A selected negative signed multiplicand carries a set sign bit, which negation flips.
    assign ext  = neg ^ (signed_mpy & mcand_msb & (single | double));
    assign term = {{(ACC_W-PP_W){ext}}, pp} + ACC_W'(neg);
endmodule

// File: rtl/booth_pp_accumulator.sv
// Serially sums five radix-4 Booth partial products into a 16-bit product, one per cycle.
// state | meaning
// IDLE  | ready for a new partial-product set
// ACC   | adding term(idx), idx = 0..4
// DONE  | product valid, waiting for out_ready
module booth_pp_accumulator
    import booth_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    booth_pp_accumulator_if.slave  bus
);
    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [ACC_W-1:0]        acc;
    logic [NUM_PP*PP_W-1:0]  pp_r;
    logic [NUM_PP-1:0]       single_r;
    logic [NUM_PP-1:0]       double_r;
    logic [NUM_PP-1:0]       neg_r;
    logic                    signed_r;
    logic                    msb_r;
    logic                    in_ready_r;
    logic                    out_valid_r;

    logic [PP_W-1:0]         pp_sel;
    logic                    single_sel;
    logic                    double_sel;
    logic                    neg_sel;
    logic [ACC_W-1:0]        term;
    logic [ACC_W-1:0]        term_shifted;
    logic [IDX_W:0]          shamt;

    always_comb begin
        pp_sel     = '0;
        single_sel = 1'b0;
        double_sel = 1'b0;
        neg_sel    = 1'b0;
        case (idx)
            3'd0: begin pp_sel = pp_r[8:0];   single_sel = single_r[0]; double_sel = double_r[0]; neg_sel = neg_r[0]; end
            3'd1: begin pp_sel = pp_r[17:9];  single_sel = single_r[1]; double_sel = double_r[1]; neg_sel = neg_r[1]; end
            3'd2: begin pp_sel = pp_r[26:18]; single_sel = single_r[2]; double_sel = double_r[2]; neg_sel = neg_r[2]; end
            3'd3: begin pp_sel = pp_r[35:27]; single_sel = single_r[3]; double_sel = double_r[3]; neg_sel = neg_r[3]; end
            3'd4: begin pp_sel = pp_r[44:36]; single_sel = single_r[4]; double_sel = double_r[4]; neg_sel = neg_r[4]; end
            default: ;
        endcase
    end

    booth_pp_extend u_extend (
        .pp         (pp_sel),
        .single     (single_sel),
        .double     (double_sel),
        .neg        (neg_sel),
        .signed_mpy (signed_r),
        .mcand_msb  (msb_r),
        .term       (term)
    );

    // Digit i has weight 4^i; bits pushed past the accumulator top are dropped.
    assign shamt        = {idx, 1'b0};
    assign term_shifted = term << shamt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            pp_r        <= '0;
            single_r    <= '0;
            double_r    <= '0;
            neg_r       <= '0;
            signed_r    <= 1'b0;
            msb_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        pp_r       <= bus.pp_in;
                        single_r   <= bus.booth_single;
                        double_r   <= bus.booth_double;
                        neg_r      <= bus.booth_negtive;
                        signed_r   <= bus.signed_mpy;
                        msb_r      <= bus.mcand_msb;
                        acc        <= '0;
                        idx        <= '0;
                        state      <= ACC;
                        in_ready_r <= 1'b0;
                    end
                end
                ACC: begin
                    acc <= acc + term_shifted;
                    idx <= idx + 3'd1;
                    if (idx == IDX_W'(NUM_PP-1)) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.product   = acc[PROD_W-1:0];
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench: a reference Booth encoder drives partial products, a monitor checks products and latency.
module tb_booth_pp_accumulator;
    logic clk;
    logic reset;

    booth_pp_accumulator_if bus ();

    booth_pp_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int accept_edge = 0;
    logic ov_prev = 1'b0;
    logic [15:0] expq [$];
    int acc_log [$];

    localparam int NV = 9;
    logic [7:0]  vx [NV] = '{8'h80, 8'hFF, 8'h7F, 8'hC8, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h80};
    logic [7:0]  vy [NV] = '{8'h80, 8'hFF, 8'h81, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h7F, 8'hFF};
    logic        vs [NV] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [15:0] ve [NV] = '{16'h4000, 16'hFE01, 16'hC0FF, 16'h0258, 16'hFFFF,
                             16'h0001, 16'h0000, 16'hC080, 16'h7F80};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference radix-4 Booth encoder plus partial-product selector.
    task automatic set_data(input logic [7:0] x, input logic [7:0] y, input logic sgn);
        logic [10:0] z;
        logic [8:0]  mx;
        logic [8:0]  sel;
        logic        b0, b1, b2, s, d, n;
        z  = {sgn & y[7], sgn & y[7], y, 1'b0};
        mx = sgn ? {x[7], x} : {1'b0, x};
        for (int i = 0; i < 5; i++) begin
            b0 = z[2*i];
            b1 = z[2*i+1];
            b2 = z[2*i+2];
            s  = b1 ^ b0;
            d  = (b2 & ~b1 & ~b0) | (~b2 & b1 & b0);
            n  = b2;
            sel = s ? mx : (d ? {x, 1'b0} : 9'd0);
            bus.pp_in[9*i +: 9]   = sel ^ {9{n}};
            bus.booth_single[i]   = s;
            bus.booth_double[i]   = d;
            bus.booth_negtive[i]  = n;
        end
        bus.signed_mpy = sgn;
        bus.mcand_msb  = x[7];
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic sgn, input logic [15:0] exp);
        int n = 0;
        set_data(x, y, sgn);
        bus.in_valid = 1'b1;
        expq.push_back(exp);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n < 50), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(expq.size()), 32'd0);
        @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (bus.in_valid && bus.in_ready) begin
                accept_edge = cyc + 1;
                acc_log.push_back(cyc + 1);
            end
            if (bus.out_valid && !ov_prev)
                check("latency", 32'(cyc - accept_edge), 32'd5);
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_product: got 0x%0h expected none", bus.product);
                end else begin
                    check("product", 32'(bus.product), 32'(expq.pop_front()));
                end
            end
        end
        ov_prev = bus.out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.pp_in         = '0;
        bus.booth_single  = '0;
        bus.booth_double  = '0;
        bus.booth_negtive = '0;
        bus.signed_mpy    = 1'b0;
        bus.mcand_msb     = 1'b0;
        bus.out_ready     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_product",   32'(bus.product),   32'd0);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            send(vx[i], vy[i], vs[i], ve[i]);
            wait_drain();
        end

        // Consumer back-pressure in DONE.
        bus.out_ready = 1'b0;
        send(8'd12, 8'd10, 1'b0, 16'h0078);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_reach_done", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("hold_product",   32'(bus.product),   32'h0078);
            check("hold_in_ready",  32'(bus.in_ready),  32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready",  32'(bus.in_ready),  32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_drained",   32'(expq.size()),   32'd0);

        // Reset in the third ACC cycle discards the partial result.
        send(8'd100, 8'd100, 1'b0, 16'h2710);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        expq.delete();
        @(negedge clk);
        reset = 1'b0;
        check("midacc_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midacc_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midacc_rst_product",   32'(bus.product),   32'd0);

        // in_valid during a reset cycle must not be taken.
        set_data(8'd3, 8'd5, 1'b0);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_valid_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_valid_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("rst_valid_in_ready2", 32'(bus.in_ready),  32'd1);
        send(8'd3, 8'd5, 1'b0, 16'h000F);
        wait_drain();

        // Continuous in_valid: back-to-back sets every 7 cycles.
        acc_log.delete();
        set_data(8'd9, 8'd9, 1'b0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expq.push_back(16'h0051);
            n = 0;
            while (!bus.in_ready && n < 30) begin
                @(negedge clk);
                n++;
            end
            check("stream_timeout", 32'(n < 30), 32'd1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_drain();
        check("stream_accepts", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() >= 3) begin
            check("stream_gap0", 32'(acc_log[1] - acc_log[0]), 32'd7);
            check("stream_gap1", 32'(acc_log[2] - acc_log[1]), 32'd7);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
